// File: rtl/count_checker_if.sv
// Tap bundle shared by the 4-bit truncated up/down counter and its checker.
// The driver of the counter (and the counter itself) owns the master side;
// the checker only listens through the slave side.
interface count_checker_if #(
   parameter int WIDTH = 4
) ();
   logic [WIDTH-1:0] din;
   logic             load;
   logic             up_down;
   logic [WIDTH-1:0] count;

   modport master (output din, load, up_down, count);
   modport slave  (input  din, load, up_down, count);
endinterface : count_checker_if

// File: rtl/count_checker.sv
// In-circuit checker for the loadable truncated up/down counter.
// Keeps its own cycle-accurate prediction of the counter, compares it with the
// observed count once per clock and keeps sticky/saturating error statistics.
module count_checker #(
   parameter int WIDTH       = 4,
   parameter int MIN_VAL     = 2,
   parameter int MAX_VAL     = 10,
   parameter int ERR_W       = 8,
   parameter int CHK_W       = 16,
   parameter int STOP_ON_ERR = 0
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              chk_en,
   input  logic              err_clr,
   count_checker_if.slave    bus,
   output logic [WIDTH-1:0]  exp_count,
   output logic              mismatch,
   output logic              err_flag,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [CHK_W-1:0]  chk_cnt,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_CHECK = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

   state_e           state_q,     state_d;
   logic [WIDTH-1:0] exp_count_q, exp_count_d;
   logic             mismatch_q,  mismatch_d;
   logic             err_flag_q,  err_flag_d;
   logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;
   logic [CHK_W-1:0] chk_cnt_q,   chk_cnt_d;

   // Counter behaviour: a load is taken verbatim (even out of range); counting
   // wraps MAX->MIN going up and MIN->MAX going down.
   function automatic logic [WIDTH-1:0] next_count(
      input logic [WIDTH-1:0] prev,
      input logic             ld,
      input logic             up,
      input logic [WIDTH-1:0] data
   );
      logic [WIDTH-1:0] nxt;
      if (ld)
         nxt = data;
      else if (up)
         nxt = (prev >= MAX_V) ? MIN_V : prev + WIDTH'(1);
      else
         nxt = (prev <= MIN_V) ? MAX_V : prev - WIDTH'(1);
      return nxt;
   endfunction

   // Next-state, prediction and statistics logic.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path can infer a latch.
      state_d     = state_q;
      exp_count_d = exp_count_q;
      mismatch_d  = 1'b0;
      err_flag_d  = err_flag_q;
      err_cnt_d   = err_cnt_q;
      chk_cnt_d   = chk_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            exp_count_d = bus.count;
            if (chk_en) state_d = ST_SYNC;
         end

         ST_SYNC: begin
            if (!chk_en) begin
               state_d     = ST_IDLE;
               exp_count_d = bus.count;
            end else begin
               // Adopt whatever the counter shows, so its reset value never matters.
               exp_count_d = next_count(bus.count, bus.load, bus.up_down, bus.din);
               state_d     = ST_CHECK;
            end
         end

         ST_CHECK: begin
            if (!chk_en) begin
               state_d     = ST_IDLE;
               exp_count_d = bus.count;
            end else begin
               if (chk_cnt_q != '1) chk_cnt_d = chk_cnt_q + CHK_W'(1);
               if (bus.count != exp_count_q) begin
                  mismatch_d = 1'b1;
                  err_flag_d = 1'b1;
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                  if (STOP_ON_ERR != 0) state_d = ST_HALT;
               end
               // The prediction continues from itself, never resyncing to count.
               exp_count_d = next_count(exp_count_q, bus.load, bus.up_down, bus.din);
            end
         end

         ST_HALT: begin
            if (!chk_en)
               state_d = ST_IDLE;
            else if (err_clr)
               state_d = ST_SYNC;
         end

         default: state_d = ST_IDLE;
      endcase

      // Clear overrides any same-cycle error update; the mismatch pulse still shows.
      if (err_clr) begin
         err_flag_d = 1'b0;
         err_cnt_d  = '0;
         chk_cnt_d  = '0;
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         exp_count_q <= '0;
         mismatch_q  <= 1'b0;
         err_flag_q  <= 1'b0;
         err_cnt_q   <= '0;
         chk_cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         exp_count_q <= exp_count_d;
         mismatch_q  <= mismatch_d;
         err_flag_q  <= err_flag_d;
         err_cnt_q   <= err_cnt_d;
         chk_cnt_q   <= chk_cnt_d;
      end
   end

   assign exp_count = exp_count_q;
   assign mismatch  = mismatch_q;
   assign err_flag  = err_flag_q;
   assign err_cnt   = err_cnt_q;
   assign chk_cnt   = chk_cnt_q;
   assign state     = state_q;

endmodule : count_checker

// File: tb/tb_count_checker.sv
// Bench for count_checker: a behavioural counter (with a glitch injector on its
// visible output) feeds three checker instances with different parameters.
// Directed steps push hand-computed expectations into a scoreboard queue; a
// monitor on the falling edge pops and compares against the selected instance.
module tb_count_checker;

   logic clock;
   logic resetn;
   logic chk_en;
   logic err_clr;
   logic inj;
   logic [3:0] inj_val;
   logic [3:0] ctr_q;

   count_checker_if #(.WIDTH(4)) bus ();

   logic [3:0]  ex_o [3];
   logic        mm_o [3];
   logic        ef_o [3];
   logic [15:0] cc_o [3];
   logic [1:0]  st_o [3];
   logic [7:0]  ec0, ec1;
   logic [1:0]  ec2;

   typedef struct {
      int dut;
      int step;
      int st;
      int ex;   // -1 means not checked
      int mm;
      int ef;
      int ec;
      int cc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_err  = 0;
   int   step_n = 0;

   count_checker #(.STOP_ON_ERR(0)) dut0 (
      .clock(clock), .resetn(resetn), .chk_en(chk_en), .err_clr(err_clr), .bus(bus.slave),
      .exp_count(ex_o[0]), .mismatch(mm_o[0]), .err_flag(ef_o[0]), .err_cnt(ec0),
      .chk_cnt(cc_o[0]), .state(st_o[0]));

   count_checker #(.STOP_ON_ERR(1)) dut1 (
      .clock(clock), .resetn(resetn), .chk_en(chk_en), .err_clr(err_clr), .bus(bus.slave),
      .exp_count(ex_o[1]), .mismatch(mm_o[1]), .err_flag(ef_o[1]), .err_cnt(ec1),
      .chk_cnt(cc_o[1]), .state(st_o[1]));

   count_checker #(.ERR_W(2)) dut2 (
      .clock(clock), .resetn(resetn), .chk_en(chk_en), .err_clr(err_clr), .bus(bus.slave),
      .exp_count(ex_o[2]), .mismatch(mm_o[2]), .err_flag(ef_o[2]), .err_cnt(ec2),
      .chk_cnt(cc_o[2]), .state(st_o[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // The counter under observation; inj replaces its visible value for a cycle.
   always @(posedge clock or negedge resetn) begin
      if (!resetn)               ctr_q <= 4'd0;
      else if (bus.load)         ctr_q <= bus.din;
      else if (bus.up_down)      ctr_q <= (ctr_q >= 4'd10) ? 4'd2  : ctr_q + 4'd1;
      else                       ctr_q <= (ctr_q <= 4'd2)  ? 4'd10 : ctr_q - 4'd1;
   end
   assign bus.count = inj ? inj_val : ctr_q;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one expectation per clock, compared away from the active edge.
   always @(negedge clock) begin
      if (sb.size() > 0) begin
         exp_t e;
         int a_st, a_ex, a_mm, a_ef, a_ec, a_cc;
         e    = sb.pop_front();
         a_st = int'(st_o[e.dut]);
         a_ex = int'(ex_o[e.dut]);
         a_mm = int'(mm_o[e.dut]);
         a_ef = int'(ef_o[e.dut]);
         a_cc = int'(cc_o[e.dut]);
         case (e.dut)
            0:       a_ec = int'(ec0);
            1:       a_ec = int'(ec1);
            default: a_ec = int'(ec2);
         endcase
         check($sformatf("d%0d s%0d state", e.dut, e.step), a_st, e.st);
         if (e.ex >= 0) check($sformatf("d%0d s%0d exp_count", e.dut, e.step), a_ex, e.ex);
         check($sformatf("d%0d s%0d mismatch", e.dut, e.step), a_mm, e.mm);
         check($sformatf("d%0d s%0d err_flag", e.dut, e.step), a_ef, e.ef);
         check($sformatf("d%0d s%0d err_cnt", e.dut, e.step), a_ec, e.ec);
         check($sformatf("d%0d s%0d chk_cnt", e.dut, e.step), a_cc, e.cc);
      end
   end

   // One clock of stimulus plus the expected outputs after that edge.
   task automatic step(input int d, input int ce, input int clr, input int ld, input int ud,
                       input int dn, input int ij, input int iv,
                       input int st, input int ex, input int mm, input int ef,
                       input int ec, input int cc);
      exp_t e;
      chk_en      = ce[0];
      err_clr     = clr[0];
      bus.load    = ld[0];
      bus.up_down = ud[0];
      bus.din     = 4'(dn);
      inj         = ij[0];
      inj_val     = 4'(iv);
      @(posedge clock);
      e = '{dut: d, step: step_n, st: st, ex: ex, mm: mm, ef: ef, ec: ec, cc: cc};
      sb.push_back(e);
      step_n++;
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
      #1;
      check("scoreboard_drain", sb.size(), 0);
   endtask

   task automatic idle_inputs();
      chk_en      = 1'b0;
      err_clr     = 1'b0;
      bus.load    = 1'b1;
      bus.up_down = 1'b1;
      bus.din     = 4'd0;
      inj         = 1'b0;
      inj_val     = 4'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      resetn = 1'b0;
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      resetn = 1'b0;
      #3;
      check("reset state",     int'(st_o[0]), 0);
      check("reset exp_count", int'(ex_o[0]), 0);
      check("reset mismatch",  int'(mm_o[0]), 0);
      check("reset err_cnt",   int'(ec0),     0);
      check("reset chk_cnt",   int'(cc_o[0]), 0);
      do_reset();

      // Phase A (default instance): in-range counting, wraps, out-of-range
      // loads, one injected glitch, err_clr alone and colliding with a mismatch.
      //   d ce clr ld ud dn ij iv   st ex mm ef ec cc
      step(0, 0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 1, 5, 0, 0,   1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 1, 5, 0, 0,   2, 5, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1, 0, 0, 0,   2, 6, 0, 0, 0, 1);
      step(0, 1, 0, 0, 1, 0, 0, 0,   2, 7, 0, 0, 0, 2);
      step(0, 1, 0, 0, 1, 0, 0, 0,   2, 8, 0, 0, 0, 3);
      step(0, 1, 0, 0, 1, 0, 0, 0,   2, 9, 0, 0, 0, 4);
      step(0, 1, 0, 0, 1, 0, 0, 0,   2,10, 0, 0, 0, 5);
      step(0, 1, 0, 0, 1, 0, 0, 0,   2, 2, 0, 0, 0, 6);
      step(0, 1, 0, 0, 1, 0, 0, 0,   2, 3, 0, 0, 0, 7);
      step(0, 1, 0, 1, 0, 3, 0, 0,   2, 3, 0, 0, 0, 8);
      step(0, 1, 0, 0, 0, 0, 0, 0,   2, 2, 0, 0, 0, 9);
      step(0, 1, 0, 0, 0, 0, 0, 0,   2,10, 0, 0, 0,10);
      step(0, 1, 0, 0, 0, 0, 0, 0,   2, 9, 0, 0, 0,11);
      step(0, 1, 0, 1, 1,12, 0, 0,   2,12, 0, 0, 0,12);
      step(0, 1, 0, 0, 1, 0, 0, 0,   2, 2, 0, 0, 0,13);
      step(0, 1, 0, 1, 0, 1, 0, 0,   2, 1, 0, 0, 0,14);
      step(0, 1, 0, 0, 0, 0, 0, 0,   2,10, 0, 0, 0,15);
      step(0, 1, 0, 1, 1, 5, 0, 0,   2, 5, 0, 0, 0,16);
      step(0, 1, 0, 0, 1, 0, 0, 0,   2, 6, 0, 0, 0,17);
      step(0, 1, 0, 0, 1, 0, 1, 7,   2, 7, 1, 1, 1,18);
      step(0, 1, 0, 0, 1, 0, 0, 0,   2, 8, 0, 1, 1,19);
      step(0, 1, 1, 0, 1, 0, 0, 0,   2, 9, 0, 0, 0, 0);
      step(0, 1, 1, 0, 1, 0, 1, 0,   2,10, 1, 0, 0, 0);
      step(0, 1, 0, 0, 1, 0, 0, 0,   2, 2, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 0, 0, 0,   0,-1, 0, 0, 0, 1);
      step(0, 0, 0, 1, 1, 4, 0, 0,   0, 3, 0, 0, 0, 1);
      drain();

      // Phase B (stop-on-error instance): halt, freeze, clear and resync.
      do_reset();
      step(1, 1, 0, 1, 1, 4, 0, 0,   1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 1, 4, 0, 0,   2, 4, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1, 0, 0, 0,   2, 5, 0, 0, 0, 1);
      step(1, 1, 0, 0, 1, 0, 1, 9,   3, 6, 1, 1, 1, 2);
      step(1, 1, 0, 0, 1, 0, 0, 0,   3, 6, 0, 1, 1, 2);
      step(1, 1, 0, 0, 1, 0, 0, 0,   3, 6, 0, 1, 1, 2);
      step(1, 1, 1, 0, 1, 0, 0, 0,   1, 6, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1, 0, 0, 0,   2,10, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1, 0, 0, 0,   2, 2, 0, 0, 0, 1);
      drain();

      // Phase C (2-bit error counter): five consecutive errors saturate at 3.
      do_reset();
      step(2, 1, 0, 1, 1, 2, 0, 0,   1, 0, 0, 0, 0, 0);
      step(2, 1, 0, 1, 1, 2, 0, 0,   2, 2, 0, 0, 0, 0);
      step(2, 1, 0, 1, 1, 2, 1, 0,   2, 2, 1, 1, 1, 1);
      step(2, 1, 0, 1, 1, 2, 1, 0,   2, 2, 1, 1, 2, 2);
      step(2, 1, 0, 1, 1, 2, 1, 0,   2, 2, 1, 1, 3, 3);
      step(2, 1, 0, 1, 1, 2, 1, 0,   2, 2, 1, 1, 3, 4);
      step(2, 1, 0, 1, 1, 2, 1, 0,   2, 2, 1, 1, 3, 5);
      step(2, 1, 0, 1, 1, 2, 0, 0,   2, 2, 0, 1, 3, 6);
      drain();

      // Asynchronous reset in the middle of a clock period, mid-CHECK/HALT.
      resetn = 1'b0;
      #1;
      check("async state d2",     int'(st_o[2]), 0);
      check("async exp_count d2", int'(ex_o[2]), 0);
      check("async err_flag d2",  int'(ef_o[2]), 0);
      check("async err_cnt d2",   int'(ec2),     0);
      check("async chk_cnt d2",   int'(cc_o[2]), 0);
      check("async state d0",     int'(st_o[0]), 0);
      check("async state d1",     int'(st_o[1]), 0);
      idle_inputs();
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;
      check("post-reset stays idle d0", int'(st_o[0]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_count_checker

// File: doc/count_checker.md
Name: count_checker

Overview:
- Synthesizable in-circuit reader/checker for the 4-bit synchronous loadable truncated up-down counter.
- Taps the same interface the counter uses: din, load, up_down and count.
- Runs a cycle-accurate reference model of the counter, compares predicted count against observed count every clock, and reports mismatches and error statistics.
- Sits beside the counter inside count_top; the testbench monitor reads its outputs as a second opinion.

Parameters:
- WIDTH, 4, counter data width.
- MIN_VAL, 2, lower bound of the count range.
- MAX_VAL, 10, upper bound of the count range.
- ERR_W, 8, width of the saturating error counter.
- CHK_W, 16, width of the saturating checks-performed counter.
- STOP_ON_ERR, 0, when 1 the checker freezes in HALT at the first mismatch.

Ports:
- clock  input  1  single system clock; all sampling on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- chk_en  input  1  enables checking; low parks the FSM in IDLE.
- err_clr  input  1  synchronous clear of err_flag, err_cnt, chk_cnt; leaves HALT.
- din  input  WIDTH  counter load data, as driven to the counter.
- load  input  1  counter load strobe (active high, priority over counting).
- up_down  input  1  1 = increment, 0 = decrement.
- count  input  WIDTH  counter output being checked.
- exp_count  output  WIDTH  predicted count for the current cycle.
- mismatch  output  1  one-cycle pulse when count != exp_count in CHECK.
- err_flag  output  1  sticky error indicator.
- err_cnt  output  ERR_W  number of mismatches, saturating.
- chk_cnt  output  CHK_W  number of comparisons performed, saturating.
- state  output  2  FSM state: IDLE=0, SYNC=1, CHECK=2, HALT=3.

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE.
  - exp_count=0, mismatch=0, err_flag=0, err_cnt=0, chk_cnt=0.
- Reference model, applied to the previous prediction P using the inputs sampled at the same edge:
  - load=1 -> next = din, taken verbatim with no range clamp.
  - load=0, up_down=1 -> next = MIN_VAL if P >= MAX_VAL, else P+1.
  - load=0, up_down=0 -> next = MAX_VAL if P <= MIN_VAL, else P-1.
  - Arithmetic is WIDTH bits; no other wrap.
- Latency: inputs sampled at edge n. Counter's count after edge n is compared at edge n+1 against exp_count produced at edge n. The comparison is registered; mismatch asserts in the cycle after the offending count.
- FSM transitions:
  - IDLE: chk_en=1 -> SYNC. Otherwise stay; exp_count tracks count; no compares.
  - SYNC (one cycle): adopt the observed count as P. exp_count <= model(count, inputs). Go to CHECK. No compare, so the counter's reset value is irrelevant.
  - CHECK, each edge:
    - chk_cnt++ (saturating).
    - If count != exp_count: pulse mismatch, set err_flag, err_cnt++ (saturating at all ones).
    - exp_count <= model(exp_count, inputs). The model keeps its own prediction after a mismatch; it does not resync to count.
    - chk_en=0 -> IDLE.
    - Mismatch with STOP_ON_ERR=1 -> HALT.
  - HALT: all outputs frozen, mismatch=0. err_clr=1 -> SYNC. chk_en=0 -> IDLE.
- err_clr:
  - In any state it zeroes err_flag, err_cnt and chk_cnt at the edge.
  - If a mismatch occurs in the same cycle, clear wins. Counters read 0, but mismatch still pulses.
- chk_en dropping mid-check: no compare on that edge; counters retained.
- Saturation: counters hold at all ones and never wrap.
- Reset mid-CHECK: immediate return to reset values. A new SYNC is required after release.
- All outputs are registered; no combinational input-to-output path.

Test Plan:
- Reset then chk_en=1, load=1 din=5, then up_down=1 for 7 clocks -> count 5,6,7,8,9,10,2,3. mismatch never asserts; chk_cnt=8; err_flag=0.
- Load din=3, up_down=0 for 3 clocks -> exp_count 3,2,10,9. No mismatch across the down wrap.
- Load din=12 (out of range) then up_down=1 -> exp 12 then 2. Load din=1 then down -> exp 1 then 10. No errors against a correct counter.
- Force count to 7 when 6 expected, STOP_ON_ERR=0 -> mismatch pulses exactly one cycle later. err_cnt=1, err_flag=1. Checking continues with exp 7 next cycle, so a correct count of 6+1=7 raises no further error.
- STOP_ON_ERR=1 with an injected error -> state=3 (HALT), outputs frozen. err_clr=1 -> state SYNC then CHECK, err_cnt=0, chk_cnt=0.
- ERR_W=2, inject 5 consecutive errors -> err_cnt saturates at 3.
- Assert resetn low mid-CHECK -> all outputs 0 and state=0 asynchronously, without waiting for a clock edge.
